// File: rtl/mem_dump_pkg.sv
// Shared types, state encoding and ASCII helpers for the memory-to-UART streamer.
package mem_dump_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StFetch = 3'd1;
    localparam state_t StLatch = 3'd2;
    localparam state_t StSend  = 3'd3;
    localparam state_t StGap   = 3'd4;
    localparam state_t StDrain = 3'd5;

    localparam logic [7:0] AsciiZero   = 8'h30;
    localparam logic [7:0] AsciiUpperA = 8'h41;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return AsciiZero + {4'd0, nib};
        end
        return AsciiUpperA + {4'd0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/mem_dump_if.sv
// Bundle of control, memory-read and UART handshake signals for mem_dump.
interface mem_dump_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned LEN_W  = 16
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              loop;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data_out;
    logic              tx_start;
    logic [7:0]        tx_char;
    logic              tx_busy;

    modport master (
        input  start, abort, base_addr, length, loop, mem_data_out, tx_busy,
        output busy, done, mem_addr, tx_start, tx_char
    );

    modport slave (
        output start, abort, base_addr, length, loop, mem_data_out, tx_busy,
        input  busy, done, mem_addr, tx_start, tx_char
    );
endinterface

// File: rtl/hex_nibble.sv
// Combinational conversion of one nibble to its uppercase ASCII hex digit.
module hex_nibble import mem_dump_pkg::*; (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    assign ascii = nibble_to_ascii(nibble);
endmodule

// File: rtl/mem_dump.sv
// Streams a byte range from synchronous memory to a UART transmitter, once or looping.
// Define MEM_DUMP_HEX_EN to send each byte as two uppercase ASCII hex digits.
module mem_dump import mem_dump_pkg::*; #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned LEN_W  = 16
) (
    input logic        CLK,
    input logic        RST,
    mem_dump_if.master bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d, rem_q, rem_d;
    logic              loop_q, loop_d, abort_q, abort_d;
    logic [7:0]        hold_q, hold_d, char_q, char_d;
    logic              tx_start_q, tx_start_d, done_q, done_d;
    logic [7:0]        send_char;
    logic              byte_last;

`ifdef MEM_DUMP_HEX_EN
    logic       nib_q, nib_d;
    logic [7:0] ascii;

    hex_nibble u_hex_nibble (
        .nibble (nib_q ? hold_q[3:0] : hold_q[7:4]),
        .ascii  (ascii)
    );

    assign send_char = ascii;
    assign byte_last = nib_q;
`else
    assign send_char = hold_q;
    assign byte_last = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        base_d     = base_q;
        len_d      = len_q;
        rem_d      = rem_q;
        loop_d     = loop_q;
        hold_d     = hold_q;
        char_d     = char_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        abort_d    = abort_q | ((state_q != StIdle) & bus.abort);
`ifdef MEM_DUMP_HEX_EN
        nib_d      = nib_q;
`endif
        case (state_q)
            StIdle: begin
                abort_d = 1'b0;
`ifdef MEM_DUMP_HEX_EN
                nib_d   = 1'b0;
`endif
                if (bus.start) begin
                    if (bus.length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        base_d  = bus.base_addr;
                        len_d   = bus.length;
                        loop_d  = bus.loop;
                        addr_d  = bus.base_addr;
                        rem_d   = bus.length;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: state_d = StLatch;
            StLatch: begin
                hold_d  = bus.mem_data_out;
                state_d = StSend;
            end
            StSend: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    char_d     = send_char;
                    state_d    = StGap;
                end
            end
            StGap: state_d = StDrain;
            StDrain: begin
                if (!bus.tx_busy) begin
`ifdef MEM_DUMP_HEX_EN
                    nib_d = ~nib_q;
`endif
                    if (!byte_last) begin
                        state_d = StSend;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        rem_d   = rem_q - LEN_W'(1);
                        state_d = StFetch;
                        // Abort only takes effect once the whole byte has gone out.
                        if (abort_d) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            abort_d = 1'b0;
                        end else if (rem_q == LEN_W'(1)) begin
                            if (loop_q) begin
                                addr_d = base_q;
                                rem_d  = len_q;
                            end else begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            loop_q     <= 1'b0;
            abort_q    <= 1'b0;
            hold_q     <= '0;
            char_q     <= '0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef MEM_DUMP_HEX_EN
            nib_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            loop_q     <= loop_d;
            abort_q    <= abort_d;
            hold_q     <= hold_d;
            char_q     <= char_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
`ifdef MEM_DUMP_HEX_EN
            nib_q      <= nib_d;
`endif
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.mem_addr = addr_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_char  = char_q;

endmodule

// File: tb/tb_mem_dump.sv
// Randomised scoreboard bench for mem_dump: a byte-stream model feeds a queue the UART monitor drains.
module tb_mem_dump;
    localparam int unsigned AW = 4;
    localparam int unsigned LW = 16;
    localparam int MEMSZ = 16;
`ifdef MEM_DUMP_HEX_EN
    localparam int CPB = 2;
`else
    localparam int CPB = 1;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;

    mem_dump_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

    mem_dump #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [MEMSZ];
    always @(posedge CLK) bus.mem_data_out <= mem[bus.mem_addr];

    // UART stand-in: busy for a random frame length starting the edge after tx_start.
    int uart_cnt = 0;
    always @(posedge CLK) begin
        if (bus.tx_start) uart_cnt <= $urandom_range(3, 10);
        else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
    end
    assign bus.tx_busy = (uart_cnt != 0);

    int vectors = 0;
    int miscompares = 0;
    int tx_count = 0;
    int done_count = 0;
    logic done_prev = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every character the DUT launches must be the next one the model predicted.
    always @(negedge CLK) begin
        if (RST) begin
            done_prev = 1'b0;
        end else begin
            if (bus.tx_start) begin
                tx_count++;
                check("tx_expected_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("tx_char", bus.tx_char, exp_q.pop_front());
            end
            if (bus.done) begin
                done_count++;
                check("done_all_sent", exp_q.size(), 0);
                check("done_busy_low", bus.busy, 0);
                check("done_one_cycle", done_prev, 0);
            end
            done_prev = bus.done;
        end
    end

    function automatic void push_byte(input logic [7:0] b);
        string s;
        if (CPB == 2) begin
            s = $sformatf("%02X", b);
            exp_q.push_back(s[0]);
            exp_q.push_back(s[1]);
        end else begin
            exp_q.push_back(b);
        end
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // abort_after > 0: pulse abort during the first character of that byte number.
    task automatic run_dump(input int base, input int len, input bit lp, input int abort_after,
                            input bit abort_with_start);
        int  nbytes;
        int  tx0;
        int  trig;
        bit  seen;
        bit  aborted;
        if (len == 0) nbytes = 0;
        else if (lp) nbytes = abort_after;
        else if (abort_after > 0 && abort_after < len) nbytes = abort_after;
        else nbytes = len;
        for (int i = 0; i < nbytes; i++) push_byte(mem[(base + (i % len)) % MEMSZ]);
        trig    = (abort_after - 1) * CPB + 1;
        aborted = 1'b0;
        tx0     = tx_count;
        @(negedge CLK);
        bus.start     = 1'b1;
        bus.base_addr = AW'(base);
        bus.length    = LW'(len);
        bus.loop      = lp;
        bus.abort     = abort_with_start;
        @(negedge CLK);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("busy_after_start", bus.busy, len != 0);
        check("done_after_start", bus.done, len == 0);
        if (len != 0) check("first_mem_addr", bus.mem_addr, base % MEMSZ);
        seen = bus.done;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge CLK);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (abort_after > 0 && !aborted && (tx_count - tx0) >= trig) begin
                bus.abort = 1'b1;
                aborted   = 1'b1;
            end
            if (c == 2 && bus.busy) begin
                bus.start     = 1'b1;
                bus.base_addr = AW'($urandom);
                bus.length    = LW'($urandom_range(1, 5));
                bus.loop      = 1'($urandom);
            end
            seen = bus.done;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("done_seen", seen, 1);
        check("char_count", tx_count - tx0, nbytes * CPB);
        if (!seen) do_reset();
        @(negedge CLK);
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
    endtask

    initial begin
        int d0;
        bit got;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.loop      = 1'b0;
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge CLK);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_char", bus.tx_char, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        RST = 1'b0;

        mem[0] = "A"; mem[1] = "B"; mem[2] = "C"; mem[3] = "D";
        run_dump(0, 4, 0, 0, 0);
        run_dump(7, 0, 0, 0, 0);
        mem[14] = "W"; mem[15] = "X"; mem[0] = "Y"; mem[1] = "Z";
        run_dump(14, 4, 0, 0, 0);
        mem[0] = "A"; mem[1] = "B";
        run_dump(0, 2, 1, 3, 0);
        run_dump(0, 2, 0, 0, 1);

        // Reset while the first character drains.
        mem[5] = "E"; mem[6] = "F"; mem[7] = "G"; mem[8] = "H";
        push_byte(mem[5]); push_byte(mem[6]); push_byte(mem[7]); push_byte(mem[8]);
        d0 = done_count;
        @(negedge CLK);
        bus.start = 1'b1; bus.base_addr = AW'(5); bus.length = LW'(4); bus.loop = 1'b0;
        @(negedge CLK);
        bus.start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (bus.tx_start) got = 1'b1;
            else @(negedge CLK);
        end
        check("mid_tx_start_seen", got, 1);
        @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_tx_start", bus.tx_start, 0);
        check("arst_tx_char", bus.tx_char, 0);
        check("arst_mem_addr", bus.mem_addr, 0);
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        check("arst_no_done", done_count - d0, 0);
        run_dump(5, 4, 0, 0, 0);

        mem[0] = 8'h4A;
        run_dump(0, 1, 0, 0, 0);

        for (int n = 0; n < 20; n++) begin
            int  base;
            int  len;
            bit  lp;
            int  ab;
            for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
            base = $urandom_range(0, MEMSZ - 1);
            len  = $urandom_range(0, 20);
            lp   = 1'($urandom);
            ab   = lp ? $urandom_range(1, 6) : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0);
            run_dump(base, len, lp, ab, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
